// File: rtl/counter_run_ctrl.sv
// Run/trigger controller for the LED counter: command-driven start/stop/clear/load,
// prescaled tick, compare-match trigger and a 4-bit LED slice of the count.
module counter_run_ctrl #(
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int LED_BASE     = 28,
  parameter bit STOP_ON_TRIG = 1'b1
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_data,
  input  logic [PRE_W-1:0] prescale,
  output logic [CNT_W-1:0] cnt,
  output logic             running,
  output logic             armed,
  output logic             trig,
  output logic             wrap,
  output logic [3:0]       led
);

  localparam logic [1:0] ST_STOPPED   = 2'd0;
  localparam logic [1:0] ST_RUNNING   = 2'd1;
  localparam logic [1:0] ST_TRIGGERED = 2'd2;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_START  = 3'b001;
  localparam logic [2:0] OP_STOP   = 3'b010;
  localparam logic [2:0] OP_CLEAR  = 3'b011;
  localparam logic [2:0] OP_LOAD   = 3'b100;
  localparam logic [2:0] OP_ARM    = 3'b101;
  localparam logic [2:0] OP_DISARM = 3'b110;
  localparam logic [2:0] OP_NOP2   = 3'b111;

  logic [1:0]       state;
  logic [PRE_W-1:0] pre_cnt;
  logic [CNT_W-1:0] match_val;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic             cmd_eff;
  logic             pre_done;
  logic             step;
  logic             hit;

  // >= rather than == so a prescale lowered below pre_cnt still ticks and restarts.
  assign accept   = cmd_valid && cmd_ready;
  assign cmd_eff  = accept && (cmd_op != OP_NOP) && (cmd_op != OP_NOP2);
  assign pre_done = (pre_cnt >= prescale);
  assign step     = running && pre_done && !cmd_eff;
  assign cnt_next = cnt + CNT_W'(1);
  assign hit      = step && armed && (cnt_next == match_val);
  assign led      = cnt[LED_BASE +: 4];

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= ST_STOPPED;
      pre_cnt   <= '0;
      match_val <= '0;
      cnt       <= '0;
      running   <= 1'b0;
      armed     <= 1'b0;
      trig      <= 1'b0;
      wrap      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      cmd_ready <= !accept;
      trig      <= hit;
      wrap      <= step && (cnt_next == '0);

      if (running) begin
        pre_cnt <= pre_done ? '0 : pre_cnt + PRE_W'(1);
      end

      if (step) begin
        cnt <= cnt_next;
      end

      if (hit) begin
        armed <= 1'b0;
        state <= ST_TRIGGERED;
        if (STOP_ON_TRIG) begin
          running <= 1'b0;
        end
      end

      // Commands override any tick in the same cycle; hit is already suppressed then.
      if (accept) begin
        case (cmd_op)
          OP_START: begin
            state   <= ST_RUNNING;
            running <= 1'b1;
            pre_cnt <= '0;
          end
          OP_STOP: begin
            if (state != ST_STOPPED) begin
              state   <= ST_STOPPED;
              running <= 1'b0;
            end
          end
          OP_CLEAR: begin
            state   <= ST_STOPPED;
            running <= 1'b0;
            cnt     <= '0;
            pre_cnt <= '0;
          end
          OP_LOAD: begin
            cnt     <= cmd_data;
            pre_cnt <= '0;
          end
          OP_ARM: begin
            armed     <= 1'b1;
            match_val <= cmd_data;
          end
          OP_DISARM: begin
            armed <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
